// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with run-time pattern reload
// and a saturating match counter.
module seq_detect_param #(
    parameter int                   PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1001,
    parameter bit                   OVERLAP = 1'b1,
    parameter int                   CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          din,
    input  logic                          din_valid,
    input  logic                          cfg_load,
    input  logic [PAT_LEN-1:0]            cfg_pattern,
    input  logic                          clr_count,
    output logic                          match,
    output logic [CNT_W-1:0]              match_count,
    output logic [$clog2(PAT_LEN+1)-1:0]  fill
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]    FULL    = FW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PAT_LEN-1:0] r_pat;
    logic [PAT_LEN-1:0] r_shreg;
    logic [FW-1:0]      r_fill;
    logic               r_match;
    logic [CNT_W-1:0]   r_cnt;

    logic [PAT_LEN-1:0] w_shreg_n;
    logic [FW-1:0]      w_fill_n;
    logic               w_shift;
    logic               w_hit;

    assign w_shift   = din_valid && !cfg_load;
    assign w_shreg_n = {r_shreg[PAT_LEN-2:0], din};
    assign w_fill_n  = (r_fill == FULL) ? FULL : r_fill + 1'b1;
    assign w_hit     = w_shift && (w_fill_n == FULL) && (w_shreg_n == r_pat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat   <= PATTERN;
            r_shreg <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (cfg_load) begin
            r_pat   <= cfg_pattern;
            r_shreg <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else if (din_valid) begin
            r_shreg <= w_shreg_n;
            // Non-overlapping mode restarts the history after a match
            r_fill  <= (w_hit && !OVERLAP) ? '0 : w_fill_n;
            r_match <= w_hit;
        end else begin
            r_match <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_count) begin
            r_cnt <= w_hit ? CNT_W'(1) : '0;
        end else if (w_hit && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign match       = r_match;
    assign match_count = r_cnt;
    assign fill        = r_fill;

endmodule
